// File: rtl/timer_digit_loader.sv
// ---------------------------------------------------------------------------
// timer_digit_loader
// Debounces keypad presses and shifts accepted digits into a 4-digit BCD
// time entry (mm:ss), most recent digit entering at the least significant
// nibble.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   data           keypad digit from the keyboard encoder
//   valid_input    high while any key is pressed
//   load_enable    high when time entry is permitted
//   clear_entry    synchronous clear of the entered time
//   time_bcd       {min_tens, min_ones, sec_tens, sec_ones}
//   digit_count    number of digits entered, 0..4
//   digit_accepted one-cycle pulse per stored digit
//   entry_full     digit_count == 4
//   entry_nonzero  time_bcd != 0
// ---------------------------------------------------------------------------
module timer_digit_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  data,
    input  logic        valid_input,
    input  logic        load_enable,
    input  logic        clear_entry,
    output logic [15:0] time_bcd,
    output logic [2:0]  digit_count,
    output logic        digit_accepted,
    output logic        entry_full,
    output logic        entry_nonzero
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DC  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam bit               DC_IS_ONE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [3:0]       r_cand;
    logic [3:0]       w_cand_nx;
    logic             w_accept;
    logic [15:0]      r_time;
    logic [2:0]       r_count;
    logic             r_digit_accepted;

    // Saturating increment of the stable-sample counter.
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_cand  <= w_cand_nx;
        end
    end

    // Next-state logic and acceptance decision.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cand_nx  = r_cand;
        w_accept   = 1'b0;
        if (!load_enable) begin
            // Parked in HELD so a key held across enable must be released first.
            w_state_nx = HELD;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_input) begin
                        w_cand_nx = data;
                        if (DC_IS_ONE) begin
                            w_accept   = 1'b1;
                            w_state_nx = HELD;
                            w_cnt_nx   = '0;
                        end else begin
                            w_state_nx = DEBOUNCE;
                            w_cnt_nx   = CNT_ONE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!valid_input) begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                    end else if (data != r_cand) begin
                        w_cand_nx = data;
                        w_cnt_nx  = CNT_ONE;
                    end else if (w_cnt_inc >= CNT_DC) begin
                        w_accept   = 1'b1;
                        w_state_nx = HELD;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                HELD: begin
                    if (!valid_input) begin
                        if (DC_IS_ONE) begin
                            w_state_nx = IDLE;
                            w_cnt_nx   = '0;
                        end else begin
                            w_state_nx = RELEASE;
                            w_cnt_nx   = CNT_ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (valid_input) begin
                        w_state_nx = HELD;
                        w_cnt_nx   = '0;
                    end else if (w_cnt_inc >= CNT_DC) begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    // Digit shift register; clear wins over a same-edge acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_time           <= '0;
            r_count          <= '0;
            r_digit_accepted <= 1'b0;
        end else begin
            r_digit_accepted <= 1'b0;
            if (clear_entry) begin
                r_time  <= '0;
                r_count <= '0;
            end else if (w_accept && (r_count < 3'd4)) begin
                r_time           <= {r_time[11:0], w_cand_nx};
                r_count          <= r_count + 3'd1;
                r_digit_accepted <= 1'b1;
            end
        end
    end

    assign time_bcd       = r_time;
    assign digit_count    = r_count;
    assign digit_accepted = r_digit_accepted;
    assign entry_full     = (r_count == 3'd4);
    assign entry_nonzero  = (r_time != 16'h0000);

endmodule

// File: tb/tb_timer_digit_loader.sv
// ---------------------------------------------------------------------------
// tb_timer_digit_loader
// Scoreboarded bench: a run-length model of the keypad predicts every stored
// digit; a negedge monitor matches digit_accepted pulses against the queue.
// ---------------------------------------------------------------------------
module tb_timer_digit_loader;

    localparam int unsigned DC = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  data;
    logic        valid_input;
    logic        load_enable;
    logic        clear_entry;
    logic [15:0] time_bcd;
    logic [2:0]  digit_count;
    logic        digit_accepted;
    logic        entry_full;
    logic        entry_nonzero;

    timer_digit_loader #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk            (clk),
        .rst            (rst),
        .data           (data),
        .valid_input    (valid_input),
        .load_enable    (load_enable),
        .clear_entry    (clear_entry),
        .time_bcd       (time_bcd),
        .digit_count    (digit_count),
        .digit_accepted (digit_accepted),
        .entry_full     (entry_full),
        .entry_nonzero  (entry_nonzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] t;
        logic [2:0]  c;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          n_pulses = 0;

    // Reference model: key is "armed" after DC consecutive released samples;
    // an armed key is stored once DC consecutive identical pressed samples occur.
    logic [15:0] m_time;
    int          m_cnt;
    bit          m_armed;
    int          m_stable;
    int          m_rel;
    logic [3:0]  m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_time   = '0;
        m_cnt    = 0;
        m_armed  = 1'b1;
        m_stable = 0;
        m_rel    = 0;
        m_last   = '0;
        exp_q.delete();
    endtask

    task automatic model_edge(input logic v, input logic le, input logic [3:0] d, input logic clr);
        bit   acc;
        exp_t e;
        acc = 1'b0;
        if (!le) begin
            m_armed  = 1'b0;
            m_rel    = 0;
            m_stable = 0;
        end else if (m_armed) begin
            if (v) begin
                if (m_stable > 0 && d == m_last) m_stable++;
                else begin
                    m_stable = 1;
                    m_last   = d;
                end
                if (m_stable >= int'(DC)) begin
                    acc      = 1'b1;
                    m_armed  = 1'b0;
                    m_stable = 0;
                    m_rel    = 0;
                end
            end else begin
                m_stable = 0;
            end
        end else begin
            if (!v) begin
                m_rel++;
                if (m_rel >= int'(DC)) begin
                    m_armed = 1'b1;
                    m_rel   = 0;
                end
            end else begin
                m_rel = 0;
            end
        end
        if (clr) begin
            m_time = '0;
            m_cnt  = 0;
        end else if (acc && m_cnt < 4) begin
            m_time = {m_time[11:0], d};
            m_cnt++;
            e.t = m_time;
            e.c = 3'(m_cnt);
            exp_q.push_back(e);
        end
    endtask

    task automatic check_state();
        chk("time_bcd", 32'(time_bcd), 32'(m_time));
        chk("digit_count", 32'(digit_count), 32'(m_cnt));
        chk("entry_full", 32'(entry_full), 32'(m_cnt == 4));
        chk("entry_nonzero", 32'(entry_nonzero), 32'(m_time != 16'h0));
    endtask

    // One clock: drive, let the edge happen, advance the model, check at negedge.
    task automatic step(input logic v, input logic le, input logic [3:0] d, input logic clr);
        valid_input = v;
        load_enable = le;
        data        = d;
        clear_entry = clr;
        @(posedge clk);
        model_edge(v, le, d, clr);
        @(negedge clk);
        check_state();
    endtask

    task automatic press(input logic [3:0] d, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, d, 1'b0);
    endtask

    task automatic release_key(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 4'h0, 1'b0);
    endtask

    // Monitor: every pulse must match the oldest predicted digit, and every
    // prediction must appear as a pulse on the following negedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (digit_accepted) begin
                n_pulses++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'(digit_accepted), 32'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_time_bcd", 32'(time_bcd), 32'(e.t));
                    chk("pulse_digit_count", 32'(digit_count), 32'(e.c));
                end
            end else if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                chk("missing_pulse", 32'(digit_accepted), 32'(1));
            end
        end
    end

    initial begin
        int p0;
        logic [3:0] d;
        int hold;
        int rel;
        int flip;
        logic le;
        rst         = 1'b1;
        data        = '0;
        valid_input = 1'b0;
        load_enable = 1'b1;
        clear_entry = 1'b0;
        model_reset();
        #2;
        chk("reset_time", 32'(time_bcd), 32'h0);
        chk("reset_count", 32'(digit_count), 32'h0);
        chk("reset_pulse", 32'(digit_accepted), 32'h0);
        chk("reset_full", 32'(entry_full), 32'h0);
        chk("reset_nonzero", 32'(entry_nonzero), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Enter 1,2,3,0.
        press(4'd1, 6); release_key(6);
        press(4'd2, 6); release_key(6);
        press(4'd3, 6); release_key(6);
        press(4'd0, 6); release_key(6);
        chk("entry_1230", 32'(time_bcd), 32'h1230);
        chk("entry_count4", 32'(digit_count), 32'd4);
        chk("entry_full4", 32'(entry_full), 32'd1);
        chk("entry_pulses", 32'(n_pulses), 32'd4);

        // Full entry ignores further digits.
        press(4'd9, 6); release_key(6);
        chk("full_hold_1230", 32'(time_bcd), 32'h1230);
        chk("full_no_pulse", 32'(n_pulses), 32'd4);

        // Clear on an acceptance edge, both full and non-full.
        press(4'd9, 3); step(1'b1, 1'b1, 4'd9, 1'b1); release_key(6);
        chk("clear_full_time", 32'(time_bcd), 32'h0);
        chk("clear_full_count", 32'(digit_count), 32'd0);
        press(4'd4, 3); step(1'b1, 1'b1, 4'd4, 1'b1); release_key(6);
        chk("clear_drop_time", 32'(time_bcd), 32'h0);
        chk("clear_drop_pulses", 32'(n_pulses), 32'd4);

        // Data changes mid-debounce: 3 is discarded, 7 accepted 4 samples later.
        press(4'd3, 2);
        press(4'd7, 3);
        chk("restart_no_early", 32'(digit_accepted), 32'd0);
        press(4'd7, 1);
        chk("restart_pulse", 32'(digit_accepted), 32'd1);
        chk("restart_time", 32'(time_bcd), 32'h0007);
        press(4'd7, 2); release_key(6);

        // Short press is ignored.
        press(4'd5, 3); release_key(6);
        chk("short_time", 32'(time_bcd), 32'h0007);
        chk("short_pulses", 32'(n_pulses), 32'd5);

        // Key held while enable rises; then a single-cycle glitch while held.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'd8, 1'b0);
        press(4'd8, 6);
        chk("enable_rise_time", 32'(time_bcd), 32'h0007);
        release_key(6);
        press(4'd8, 6);
        step(1'b0, 1'b1, 4'd8, 1'b0);
        press(4'd8, 6);
        release_key(6);
        chk("glitch_time", 32'(time_bcd), 32'h0078);
        chk("glitch_pulses", 32'(n_pulses), 32'd6);

        // Asynchronous reset in the middle of a debounce.
        press(4'd2, 2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_time", 32'(time_bcd), 32'h0);
        chk("async_rst_count", 32'(digit_count), 32'h0);
        chk("async_rst_nonzero", 32'(entry_nonzero), 32'h0);
        chk("async_rst_full", 32'(entry_full), 32'h0);
        model_reset();
        #1 rst = 1'b0;
        p0 = n_pulses;
        release_key(6);
        chk("post_rst_time", 32'(time_bcd), 32'h0);
        chk("post_rst_pulses", 32'(n_pulses), 32'(p0));

        // Randomized presses with glitches, enable drops and clears.
        for (int k = 0; k < 80; k++) begin
            d    = 4'($urandom_range(0, 15));
            hold = int'($urandom_range(1, 8));
            rel  = int'($urandom_range(1, 8));
            flip = int'($urandom_range(0, 12));
            le   = ($urandom_range(0, 9) != 0);
            for (int j = 0; j < hold; j++)
                step(1'b1, le, (j == flip) ? 4'($urandom_range(0, 15)) : d,
                     ($urandom_range(0, 29) == 0));
            for (int j = 0; j < rel; j++)
                step(1'b0, 1'b1, 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 29) == 0));
        end
        release_key(6);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/timer_digit_loader.md
TIMER_DIGIT_LOADER -- requirements
Module: timer_digit_loader

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable samples needed to accept a press or a release; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port data, input, 4 bits: keypad digit 0..9 from the keyboard encoder.
REQ-005 The block SHALL have port valid_input, input, 1 bit: high while any key is pressed.
REQ-006 The block SHALL have port load_enable, input, 1 bit: high when the controller permits time entry.
REQ-007 The block SHALL have port clear_entry, input, 1 bit: synchronous clear of the entered time.
REQ-008 The block SHALL have port time_bcd, output, 16 bits: {min_tens, min_ones, sec_tens, sec_ones}, each a BCD nibble.
REQ-009 The block SHALL have port digit_count, output, 3 bits: number of digits entered, 0..4.
REQ-010 The block SHALL have port digit_accepted, output, 1 bit: one-cycle pulse per accepted digit.
REQ-011 The block SHALL have port entry_full, output, 1 bit: high when digit_count==4.
REQ-012 The block SHALL have port entry_nonzero, output, 1 bit: high when time_bcd!=0.

Function
REQ-013 The FSM SHALL have states IDLE, DEBOUNCE, HELD and RELEASE.
REQ-014 In IDLE, when valid_input=1 and load_enable=1, the FSM SHALL latch data as the candidate, set the counter to 1, and go to DEBOUNCE; if DEBOUNCE_CYCLES==1 it SHALL instead accept on that edge.
REQ-015 In DEBOUNCE, on each edge with valid_input=1 and data==candidate, the counter SHALL increment; acceptance SHALL occur on the edge where the count reaches DEBOUNCE_CYCLES.
REQ-016 In DEBOUNCE, when valid_input=0 the FSM SHALL return to IDLE, and when data!=candidate it SHALL relatch data and restart the count at 1.
REQ-017 On acceptance the FSM SHALL go to HELD.
REQ-018 On acceptance with digit_count<4, the digits SHALL shift left one nibble (time_bcd <= {time_bcd[11:0], candidate}), digit_count SHALL increment, and digit_accepted SHALL be 1 for exactly the next cycle.
REQ-019 On acceptance with digit_count==4, time_bcd and digit_count SHALL be unchanged and digit_accepted SHALL stay 0, while the FSM still goes to HELD.
REQ-020 In HELD, valid_input=0 SHALL move the FSM to RELEASE with the counter at 1.
REQ-021 In RELEASE, each edge with valid_input=0 SHALL increment the counter, and reaching DEBOUNCE_CYCLES SHALL move the FSM to IDLE.
REQ-022 In RELEASE, valid_input=1 SHALL return the FSM to HELD.
REQ-023 With DEBOUNCE_CYCLES==1, the first valid_input=0 edge in HELD SHALL move the FSM directly to IDLE.
REQ-024 Whenever load_enable=0, the FSM SHALL go to HELD, so a key held across enable rising is not accepted until it has been released.
REQ-025 clear_entry=1 SHALL zero time_bcd and digit_count on that edge, SHALL take priority over a same-edge acceptance (that digit is dropped, no pulse), and SHALL NOT change the FSM transition.
REQ-026 Digit values >9 SHALL be stored unmodified; range checking belongs downstream.
REQ-027 entry_full and entry_nonzero SHALL be combinational decodes of the registered state.
REQ-028 The counter SHALL be wide enough for DEBOUNCE_CYCLES and SHALL saturate, never wrap.

Reset
REQ-029 rst=1 SHALL immediately force FSM=IDLE, counter=0, candidate=0, time_bcd=16'h0000, digit_count=0 and digit_accepted=0, independent of clk.
REQ-030 Hence entry_full=0 and entry_nonzero=0 during reset.
REQ-031 Reset asserted mid-debounce or mid-hold SHALL discard the press in progress.
REQ-032 After rst deassertion with valid_input=1, a press SHALL NOT be accepted until DEBOUNCE_CYCLES stable samples have been taken.

Verification
REQ-033 DEBOUNCE_CYCLES=4, load_enable=1, press 1,2,3,0 (each held 6 cycles, released 6 cycles) -> time_bcd=16'h1230, digit_count=4, entry_full=1, four single-cycle digit_accepted pulses.
REQ-034 Press 5 held for 3 cycles, then released -> no change to time_bcd, digit_accepted never asserted.
REQ-035 data changes 3->7 during debounce with valid_input held high -> count restarts, 7 accepted 4 stable cycles after the change, 3 never stored.
REQ-036 When full (16'h1230), press 9 -> time_bcd stays 16'h1230, no pulse; then clear_entry on the same edge as an acceptance -> time_bcd=0, digit_count=0, no pulse.
REQ-037 Key held while load_enable rises 0->1 -> no acceptance until release plus a fresh press; a 1-cycle glitch low during HELD -> no second acceptance.
REQ-038 rst pulsed asynchronously between clock edges while in DEBOUNCE -> all outputs 0 immediately, and the press is not accepted afterwards.
